// File: rtl/regfile_pkg.sv
// Shared constants for the architectural register file: control levels and
// the 4-bit register address map (R0-R7, SP, IH, RA, T).
package regfile_pkg;
  localparam int REG_BUS_W      = 16;
  localparam int REG_ADDR_BUS_W = 4;
  localparam int NUM_REGS       = 12;

  localparam logic RST_ACTIVE_LOW = 1'b0;
  localparam logic ENABLE         = 1'b1;
  localparam logic DISABLE        = 1'b0;

  localparam logic [REG_BUS_W-1:0]      ZERO_WORD = '0;
  localparam logic [REG_ADDR_BUS_W-1:0] REG_ZERO  = 4'h0;
  localparam logic [REG_ADDR_BUS_W-1:0] REG_SP    = 4'h8;
  localparam logic [REG_ADDR_BUS_W-1:0] REG_IH    = 4'h9;
  localparam logic [REG_ADDR_BUS_W-1:0] REG_RA    = 4'hA;
  localparam logic [REG_ADDR_BUS_W-1:0] REG_T     = 4'hB;
  localparam logic [REG_ADDR_BUS_W-1:0] REG_LAST  = 4'hB;
endpackage

// File: rtl/regfile.sv
// Register file R0-R7/SP/IH/RA/T with two combinational read ports and
// same-cycle writeback bypass; addresses 0xC-0xF read as zero and drop writes.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_BUS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wData_i,
  input  logic              wReg_i,
  input  logic [ADDR_W-1:0] wRegAddr_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] rAddr1_i,
  output logic [DATA_W-1:0] rData1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] rAddr2_i,
  output logic [DATA_W-1:0] rData2_o,
  output logic [DATA_W-1:0] sp_o,
  output logic              intEn_o
);

  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
  logic [NUM_REGS-1:0]             w_we;

  // Per-entry decode keeps out-of-range writes from touching storage.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
    assign w_we[i] = (wReg_i == ENABLE) && (wRegAddr_i == ADDR_W'(i));

    always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ACTIVE_LOW)
        r_regs[i] <= '0;
      else if (w_we[i])
        r_regs[i] <= wData_i;
    end
  end

  // Unimplemented-address check sits ahead of the bypass on purpose.
  function automatic logic [DATA_W-1:0] rf_read_mux(input logic re,
                                                    input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    if (rst != RST_ACTIVE_LOW && re == ENABLE && addr <= ADDR_W'(REG_LAST)) begin
      if (wReg_i == ENABLE && wRegAddr_i == addr)
        val = wData_i;
      else
        for (int i = 0; i < NUM_REGS; i++)
          if (addr == ADDR_W'(i)) val = r_regs[i];
    end
    return val;
  endfunction

  assign rData1_o = rf_read_mux(re1_i, rAddr1_i);
  assign rData2_o = rf_read_mux(re2_i, rAddr2_i);

  assign sp_o    = r_regs[int'(REG_SP)];
  assign intEn_o = r_regs[int'(REG_IH)][DATA_W-1];

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: reset, write/read, bypass, special registers,
// unimplemented addresses and asynchronous reset mid-operation.
module tb_regfile;
  logic        clk, rst;
  logic [15:0] wData_i;
  logic        wReg_i;
  logic [3:0]  wRegAddr_i;
  logic        re1_i, re2_i;
  logic [3:0]  rAddr1_i, rAddr2_i;
  logic [15:0] rData1_o, rData2_o, sp_o;
  logic        intEn_o;

  int n_cmp = 0;
  int n_err = 0;

  regfile #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .wData_i(wData_i), .wReg_i(wReg_i), .wRegAddr_i(wRegAddr_i),
    .re1_i(re1_i), .rAddr1_i(rAddr1_i), .rData1_o(rData1_o),
    .re2_i(re2_i), .rAddr2_i(rAddr2_i), .rData2_o(rData2_o),
    .sp_o(sp_o), .intEn_o(intEn_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    wReg_i = 1'b1; wRegAddr_i = a; wData_i = d;
  endtask

  task automatic idle();
    wReg_i = 1'b0; wRegAddr_i = 4'h0; wData_i = 16'h0;
  endtask

  task automatic rd(input logic [3:0] a1, input logic [3:0] a2);
    re1_i = 1'b1; rAddr1_i = a1; re2_i = 1'b1; rAddr2_i = a2;
  endtask

  initial begin
    rst = 1'b0; idle(); rd(4'h0, 4'h0);

    // Reset: every address reads zero on both ports
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), 4'(15 - a)); #1;
      chk($sformatf("rst_p1_%0d", a), rData1_o, 16'h0);
      chk($sformatf("rst_p2_%0d", 15 - a), rData2_o, 16'h0);
    end
    chk("rst_sp", sp_o, 16'h0);
    chk("rst_inten", {15'h0, intEn_o}, 16'h0);
    @(negedge clk); rst = 1'b1; rd(4'h3, 4'h8); #1;
    chk("post_rst_p1", rData1_o, 16'h0);
    chk("post_rst_p2", rData2_o, 16'h0);

    // Basic write / read
    @(negedge clk); wr(4'h3, 16'h1234);
    @(negedge clk); idle(); rd(4'h3, 4'h4); #1;
    chk("r3_p1", rData1_o, 16'h1234);
    chk("r4_p2", rData2_o, 16'h0);
    re2_i = 1'b0; rAddr2_i = 4'h3; #1;
    chk("re2_low", rData2_o, 16'h0);

    // Bypass on both ports, then stale-free read with write disabled
    @(negedge clk); wr(4'h5, 16'hBEEF); rd(4'h5, 4'h5); #1;
    chk("byp_p1", rData1_o, 16'hBEEF);
    chk("byp_p2", rData2_o, 16'hBEEF);
    @(negedge clk); wReg_i = 1'b0; wRegAddr_i = 4'h5; wData_i = 16'hFFFF; #1;
    chk("nobyp_p1", rData1_o, 16'hBEEF);
    chk("nobyp_p2", rData2_o, 16'hBEEF);

    // SP: bypassed on read port, sp_o only after the edge
    @(negedge clk); wr(4'h8, 16'hBF00); rd(4'h8, 4'h8); #1;
    chk("sp_before", sp_o, 16'h0);
    chk("sp_byp", rData1_o, 16'hBF00);
    @(negedge clk); idle(); #1;
    chk("sp_after", sp_o, 16'hBF00);

    // IH bit 15 drives intEn
    @(negedge clk); wr(4'h9, 16'h8000); #1;
    chk("ih_before", {15'h0, intEn_o}, 16'h0);
    @(negedge clk); idle(); #1;
    chk("inten_set", {15'h0, intEn_o}, 16'h1);
    @(negedge clk); wr(4'h9, 16'h0001);
    @(negedge clk); idle(); #1;
    chk("inten_clr", {15'h0, intEn_o}, 16'h0);

    // Unimplemented address: zero same cycle (beats bypass) and next cycle
    @(negedge clk); wr(4'hD, 16'h5555); rd(4'hD, 4'hD); #1;
    chk("unimp_byp_p1", rData1_o, 16'h0);
    chk("unimp_byp_p2", rData2_o, 16'h0);
    @(negedge clk); idle(); #1;
    chk("unimp_next", rData1_o, 16'h0);
    rd(4'h3, 4'h5); #1;
    chk("keep_r3", rData1_o, 16'h1234);
    chk("keep_r5", rData2_o, 16'hBEEF);
    rd(4'h9, 4'hA); #1;
    chk("keep_ih", rData1_o, 16'h0001);
    chk("keep_ra", rData2_o, 16'h0);
    rd(4'hB, 4'h5); #1;
    chk("keep_t", rData1_o, 16'h0);
    chk("keep_sp", sp_o, 16'hBF00);

    // T holds a full word
    @(negedge clk); wr(4'hB, 16'hABCD);
    @(negedge clk); idle(); rd(4'hB, 4'hA); #1;
    chk("t_word", rData1_o, 16'hABCD);

    // Fill R0-R7, set IH so intEn is visibly cleared by reset
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); wr(4'(i), 16'(16'h0101 * (i + 1)));
    end
    @(negedge clk); wr(4'h9, 16'h8000);
    @(negedge clk); idle(); rd(4'h0, 4'h7); #1;
    chk("fill_r0", rData1_o, 16'h0101);
    chk("fill_r7", rData2_o, 16'h0808);
    chk("pre_rst_inten", {15'h0, intEn_o}, 16'h1);

    // Async reset between edges clears everything immediately
    #2; rst = 1'b0; #1;
    chk("arst_p1", rData1_o, 16'h0);
    chk("arst_p2", rData2_o, 16'h0);
    chk("arst_sp", sp_o, 16'h0);
    chk("arst_inten", {15'h0, intEn_o}, 16'h0);
    @(negedge clk); wr(4'h1, 16'hAAAA);
    @(negedge clk); idle(); rst = 1'b1; rd(4'h1, 4'h7); #1;
    chk("drop_r1", rData1_o, 16'h0);
    chk("cleared_r7", rData2_o, 16'h0);
    chk("cleared_sp", sp_o, 16'h0);

    // First write after release is accepted
    wr(4'h2, 16'h7777);
    @(negedge clk); idle(); rd(4'h2, 4'h1); #1;
    chk("first_wr_r2", rData1_o, 16'h7777);
    chk("first_wr_r1", rData2_o, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
